piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the 4-stage serial shift register and drives its serial input, one bit per clock.
- Accepts a WIDTH-bit word through a valid/ready handshake and emits it LSB-first, with framing strobes for downstream consumers.
- Back-to-back words stream with no idle bubble.
- The downstream path has no backpressure, so once a word starts it always completes unless reset.

Parameters:
- WIDTH, 64: word width in bits; legal range is WIDTH >= 2.
- MSB_FIRST, 0: 0 emits bit 0 first; 1 emits bit WIDTH-1 first.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- load_data  input  WIDTH  parallel word to serialize
- load_valid  input  1  load_data is valid
- load_ready  output  1  block can accept a word this cycle
- ser_out  output  1  serial bit; feeds the shift register's serial input
- ser_valid  output  1  ser_out carries a payload bit this cycle
- ser_first  output  1  ser_out is the first bit of a word
- ser_last  output  1  ser_out is the last bit of a word
- busy  output  1  a word is in flight (state SHIFT)

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high.
- Reset values: state=IDLE, shreg=0, cnt=0, ser_out=0, ser_valid=0, ser_first=0, ser_last=0, busy=0, load_ready=1 (load_ready follows the IDLE state combinationally).
- State IDLE:
  - load_ready=1; ser_out=0; all strobes are 0.
  - Accept condition: load_valid && load_ready sampled at a rising edge.
  - On accept: shreg<=load_data, cnt<=0, state<=SHIFT.
- State SHIFT:
  - ser_out=shreg[0] (MSB_FIRST=0) or shreg[WIDTH-1] (MSB_FIRST=1).
  - ser_valid=1, busy=1, ser_first=(cnt==0), ser_last=(cnt==WIDTH-1).
  - At each edge with cnt<WIDTH-1: shreg shifts toward the output end, a 0 fills the vacated bit, cnt<=cnt+1.
- Last-bit cycle (cnt==WIDTH-1):
  - load_ready=1.
  - If load_valid at that edge: reload shreg, set cnt<=0, stay in SHIFT. The next cycle shows the new word's first bit with ser_first=1 (zero-bubble streaming).
  - Otherwise: state<=IDLE.
- In SHIFT with cnt<WIDTH-1: load_ready=0, and load_valid is ignored (the word stays pending upstream).
- Latency: word accepted at edge N; bit 0 is on ser_out during cycle N+1; the last bit is on ser_out during cycle N+WIDTH.
- Counter width: $clog2(WIDTH). cnt never exceeds WIDTH-1; no wrap beyond it.
- ser_out, ser_first and ser_last are driven only from state, shreg and cnt flops; there are no combinational paths from inputs.
- Reset mid-word: the word in flight is discarded and all outputs return to reset values on the next cycle. The upstream source must re-present any word it still needs.
- Simultaneous reset and load_valid: reset wins; no word is accepted.
- load_data is sampled only at an accept edge; changes at any other time have no effect.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=1'b0, ST_SHIFT=1'b1) and a bit-order constant used with MSB_FIRST.
- One natural sub-module: bit_counter, a modulo-WIDTH up-counter with clear/enable/terminal-count output, reusable by a future deserializer.
- The shift register itself stays inline.

Test Plan:
- Reset then idle: assert reset 2 cycles, no load_valid -> load_ready=1, ser_valid=0, ser_out=0, busy=0 for 10 cycles.
- Single word, WIDTH=8, MSB_FIRST=0: load_data=8'hA5 with one load_valid pulse -> ser_out sequence 1,0,1,0,0,1,0,1 over cycles N+1..N+8; ser_first only on cycle N+1, ser_last only on cycle N+8; back to IDLE at N+9.
- Back-to-back, WIDTH=8: 8'h0F then 8'hF0 with load_valid held -> 16 consecutive ser_valid=1 cycles reading 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1; ser_first on bits 1 and 9; load_ready high only on cycles 8 and 16.
- Load while busy: load_valid=1 with 8'hFF at the 3rd bit of an 8'h00 word -> load_ready=0 and no capture; 8'hFF is accepted at the last-bit edge and serialized starting the next cycle.
- MSB_FIRST=1, WIDTH=4: load_data=4'b1000 -> ser_out 1,0,0,0.
- Reset mid-word: reset at the 4th bit of 8'hFF -> the next cycle has ser_valid=0, busy=0, load_ready=1; a subsequent 8'h01 serializes cleanly as 1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
// This package holds the FSM state encoding and the bit-order constants.
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // These values are compared against the MSB_FIRST parameter of the serializer.
  localparam bit ORDER_LSB_FIRST = 1'b0;
  localparam bit ORDER_MSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Modulo-MODULUS up-counter with synchronous clear, enable and terminal-count flag.
// A future deserializer can reuse it to count bit positions.
module bit_counter #(
  parameter int MODULUS = 8,
  parameter int CW      = $clog2(MODULUS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          terminal
);

  localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

  assign terminal = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer. It accepts a word through valid/ready and emits it one bit per clock.
// It raises first/last framing strobes, and consecutive words follow each other with no idle cycle.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW      = $clog2(WIDTH);
  localparam int OUT_IDX = (MSB_FIRST == ORDER_MSB_FIRST) ? WIDTH - 1 : 0;

  state_e           state, state_next;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             cnt_last;
  logic             cnt_clear;
  logic             cnt_en;
  logic             accept;

  // On the last-bit cycle the next word can be taken, which keeps the stream free of bubbles.
  assign load_ready = (state == ST_IDLE) || cnt_last;
  assign accept     = load_valid && load_ready;

  // NOTE: sequential state is written with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_SHIFT;
          cnt_clear  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_last) begin
          cnt_clear = 1'b1;
          if (!load_valid) state_next = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
    endcase
  end

  bit_counter #(
    .MODULUS (WIDTH),
    .CW      (CW)
  ) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .count    (cnt),
    .terminal (cnt_last)
  );

  // NOTE: shreg is a plain register rather than a memory, so it is reset. Its output is also gated by state.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= load_data;
    end else if (cnt_en) begin
      shreg <= (MSB_FIRST == ORDER_MSB_FIRST) ? {shreg[WIDTH-2:0], 1'b0}
                                              : {1'b0, shreg[WIDTH-1:1]};
    end
  end

  assign ser_valid = (state == ST_SHIFT);
  assign busy      = ser_valid;
  assign ser_first = ser_valid && (cnt == '0);
  assign ser_last  = ser_valid && cnt_last;
  assign ser_out   = ser_valid && shreg[OUT_IDX];

endmodule
